// File: rtl/tanh_segment_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tanh_segment_fetch
// Description : Two-stage valid/ready feeder for the LSTM tanh piecewise-
//               linear interpolator. It splits a Q4.4 sample into a segment
//               index and a fraction, looks up the segment endpoints in a
//               17-entry tanh table, and flags the last sample of each vector.
// Revision    : 1.0 - initial release
// ============================================================================
module tanh_segment_fetch #(
  parameter int VEC_LEN = 16,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic signed [7:0] x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic signed [7:0] base,
  output logic signed [7:0] next_data,
  output logic signed [7:0] change,
  output logic signed [7:0] remaining,
  output logic              out_last
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // tanh(i-8) * 16, rounded; the table saturates at +/-16 outside +/-3
  function automatic logic signed [7:0] tanh_table(input logic [4:0] i);
    logic signed [7:0] v;
    case (i)
      5'd6:    v = -8'sd15;
      5'd7:    v = -8'sd12;
      5'd8:    v = 8'sd0;
      5'd9:    v = 8'sd12;
      5'd10:   v = 8'sd15;
      default: v = (i < 5'd6) ? -8'sd16 : 8'sd16;
    endcase
    return v;
  endfunction

  logic             advance;
  logic             s1_valid;
  logic [4:0]       s1_idx;
  logic [3:0]       s1_frac;
  logic [4:0]       idx_in;
  logic [4:0]       idx_next;
  logic signed [7:0] t_lo;
  logic signed [7:0] t_hi;
  logic [CNT_W-1:0] cnt;
  logic             out_fire;

  // One global enable: both stages move whenever the output slot is free
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Adding 8 to a 4-bit two's-complement integer is a flip of its sign bit
  assign idx_in   = {1'b0, ~x[7], x[6:4]};
  assign idx_next = s1_idx + 5'd1;
  assign t_lo     = tanh_table(s1_idx);
  assign t_hi     = tanh_table(idx_next);

  assign out_fire = out_valid && out_ready;
  assign out_last = out_valid && (cnt == LAST_CNT);

  // Stage 1: capture the segment index and fraction of the incoming sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_frac  <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_idx   <= idx_in;
      s1_frac  <= x[3:0];
    end
  end

  // Stage 2: register the table endpoints, their difference and the fraction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      base      <= '0;
      next_data <= '0;
      change    <= '0;
      remaining <= '0;
    end else if (advance) begin
      out_valid <= s1_valid;
      base      <= t_lo;
      next_data <= t_hi;
      change    <= t_hi - t_lo;
      remaining <= {4'b0000, s1_frac};
    end
  end

  // Per-vector sample counter, advanced only by completed output handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (out_fire) begin
      if (cnt == LAST_CNT) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tanh_segment_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_tanh_segment_fetch
// Description : Directed self-checking bench for tanh_segment_fetch. The main
//               instance uses VEC_LEN=4; a second VEC_LEN=1 instance shares
//               the inputs and must flag every valid output as last.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tanh_segment_fetch;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] x;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] base;
  logic signed [7:0] next_data;
  logic signed [7:0] change;
  logic signed [7:0] remaining;
  logic              out_last;

  logic              in_ready1;
  logic              out_valid1;
  logic signed [7:0] base1;
  logic signed [7:0] next_data1;
  logic signed [7:0] change1;
  logic signed [7:0] remaining1;
  logic              out_last1;

  int checks;
  int errors;
  logic [7:0] xs [0:15];

  tanh_segment_fetch #(.VEC_LEN(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .out_valid(out_valid), .out_ready(out_ready), .base(base),
    .next_data(next_data), .change(change), .remaining(remaining),
    .out_last(out_last)
  );

  tanh_segment_fetch #(.VEC_LEN(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .x(x), .out_valid(out_valid1), .out_ready(out_ready), .base(base1),
    .next_data(next_data1), .change(change1), .remaining(remaining1),
    .out_last(out_last1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference tanh table from the tanh definition points
  function automatic int tanh_ref(input int i);
    if (i <= 5) return -16;
    if (i == 6) return -15;
    if (i == 7) return -12;
    if (i == 8) return 0;
    if (i == 9) return 12;
    if (i == 10) return 15;
    return 16;
  endfunction

  function automatic int seg_of(input logic [7:0] v);
    logic signed [3:0] ip;
    ip = v[7:4];
    return int'(ip) + 8;
  endfunction

  task automatic apply_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    x         = 8'h00;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Sends one sample, checks it two edges later, then lets it drain
  task automatic send_one(input logic [7:0] xv, input int eb, input int en,
                          input int ec, input int er, input logic el,
                          input string name);
    in_valid = 1'b1;
    x = xv;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL %s early_valid: got %0b expected 0", name, out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || int'(base) != eb || int'(next_data) != en ||
        int'(change) != ec || int'(remaining) != er || out_last !== el ||
        out_last1 !== 1'b1) begin
      errors++;
      $display("FAIL %s: got v=%0b b=%0d n=%0d c=%0d r=%0d l=%0b l1=%0b expected v=1 b=%0d n=%0d c=%0d r=%0d l=%0b l1=1",
               name, out_valid, base, next_data, change, remaining, out_last, out_last1,
               eb, en, ec, er, el);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL %s duplicate: got out_valid=%0b expected 0", name, out_valid);
    end
  endtask

  // Streams xs[0..n-1]; out_ready is low for stall_len cycles from stall_at
  task automatic stream(input int n, input int stall_at, input int stall_len,
                        input int cnt0, input string name);
    int sent, recv, cyc, k, eb, en;
    sent = 0; recv = 0; cyc = 0;
    while (recv < n && cyc < 200) begin
      out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      in_valid  = (sent < n);
      x         = (sent < n) ? xs[sent] : 8'h00;
      #1;
      if (out_valid) begin
        checks++;
        if (recv >= n) begin
          errors++; $display("FAIL %s extra_output: got output %0d expected %0d outputs", name, recv, n);
        end else begin
          k  = seg_of(xs[recv]);
          eb = tanh_ref(k);
          en = tanh_ref(k + 1);
          if (int'(base) != eb || int'(next_data) != en || int'(change) != en - eb ||
              int'(remaining) != int'(xs[recv][3:0]) ||
              out_last !== (((cnt0 + recv) % 4) == 3) || out_last1 !== 1'b1) begin
            errors++;
            $display("FAIL %s out%0d: got b=%0d n=%0d c=%0d r=%0d l=%0b l1=%0b expected b=%0d n=%0d c=%0d r=%0d l=%0b l1=1",
                     name, recv, base, next_data, change, remaining, out_last, out_last1,
                     eb, en, en - eb, xs[recv][3:0], (((cnt0 + recv) % 4) == 3));
          end
        end
        if (!out_ready) begin
          checks++;
          if (in_ready !== 1'b0) begin
            errors++; $display("FAIL %s stall_in_ready: got %0b expected 0", name, in_ready);
          end
        end
      end
      if (out_valid && out_ready) recv++;
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (recv != n) begin
      errors++; $display("FAIL %s count: got %0d outputs expected %0d", name, recv, n);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL %s drain: got out_valid=%0b expected 0", name, out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; x = 8'h10; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || base !== 8'sd0 || next_data !== 8'sd0 ||
        change !== 8'sd0 || remaining !== 8'sd0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got v=%0b b=%0d n=%0d c=%0d r=%0d l=%0b expected all 0",
               out_valid, base, next_data, change, remaining, out_last);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: got in_ready=%0b out_valid=%0b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    send_one(8'h00, 0, 12, 12, 0, 1'b0, "x_00");
    apply_reset();
    send_one(8'h18, 12, 15, 3, 8, 1'b0, "x_18");
    send_one(8'hE8, -15, -12, 3, 8, 1'b0, "x_E8");
  endtask

  task automatic test_extremes();
    apply_reset();
    send_one(8'h80, -16, -16, 0, 0, 1'b0, "x_80");
    send_one(8'h7F, 16, 16, 0, 15, 1'b0, "x_7F");
  endtask

  task automatic test_stall();
    apply_reset();
    xs[0] = 8'h00; xs[1] = 8'h18; xs[2] = 8'hE8; xs[3] = 8'h80; xs[4] = 8'h7F;
    stream(5, 3, 3, 0, "stall");
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 9; i++) xs[i] = 8'(i * 29 + 3);
    stream(9, 1000, 0, 0, "b2b");
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    xs[0] = 8'h21; xs[1] = 8'hC4; xs[2] = 8'h0F;
    stream(3, 1000, 0, 0, "pre_rst");
    in_valid = 1'b1; x = 8'h20;
    @(posedge clk); #1;
    x = 8'h30;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || base !== 8'sd0 || out_last !== 1'b0) begin
      errors++; $display("FAIL async_reset: got v=%0b b=%0d l=%0b expected 0 0 0", out_valid, base, out_last);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL flushed: got out_valid=%0b expected 0", out_valid);
      end
    end
    send_one(8'h10, 12, 15, 3, 0, 1'b0, "post_rst_x_10");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_extremes();
    test_stall();
    test_back_to_back();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
